// File: rtl/uart_pkg.sv
// Shared definitions for the configurable UART: parity modes, FSM state
// encoding and a counter-width helper used by the bit-period generator.
package uart_pkg;

    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PAR,
        STOP
    } state_t;

    // A divide-by-one counter still needs one bit to exist.
    function automatic int cnt_width(input int div);
        return (div > 1) ? $clog2(div) : 1;
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period counter: tick marks the last clk cycle of each CLKDIV-cycle bit.
// restart holds the count at zero so the next bit starts on a clean boundary.
module uart_baud_gen
    import uart_pkg::*;
#(
    parameter int CLKDIV = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic restart,
    output logic tick
);

    localparam int            CW   = cnt_width(CLKDIV);
    localparam logic [CW-1:0] LAST = CW'(CLKDIV - 1);

    logic [CW-1:0] cnt;

    assign tick = (cnt == LAST);

    // NOTE: sequential state uses non-blocking assignment so every register
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk) begin
        if (rst || restart || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/uart_tx_cfg.sv
// Configurable UART transmitter: start bit, LSB-first data, optional parity,
// one or two stop bits; accepts a new frame in the last stop cycle.
module uart_tx_cfg
    import uart_pkg::*;
#(
    parameter int CLKDIV    = 16,
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DATA_BITS-1:0] data,
    input  logic                 send,
    output logic                 ready,
    output logic                 sent,
    output logic                 busy,
    output logic                 tx
);

    localparam int            BW        = $clog2(DATA_BITS);
    localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_BITS - 1);
    localparam logic          LAST_STOP = 1'(STOP_BITS - 1);

    state_t               state, state_next;
    logic [DATA_BITS-1:0] shreg, shreg_next;
    logic [BW-1:0]        bit_cnt, bit_next;
    logic                 stop_cnt, stop_next;
    logic                 par_q, par_next;
    logic                 tx_q, tx_next;
    logic                 tick, restart, accept, last_stop;

    uart_baud_gen #(.CLKDIV(CLKDIV)) u_baud (
        .clk     (clk),
        .rst     (rst),
        .restart (restart),
        .tick    (tick)
    );

    assign last_stop = (state == STOP) && tick && (stop_cnt == LAST_STOP);
    assign ready     = !rst && ((state == IDLE) || last_stop);
    assign accept    = send && ready;
    assign sent      = !rst && last_stop;
    assign busy      = !rst && (state != IDLE);
    assign restart   = (state == IDLE) || accept;
    assign tx        = tx_q;

    // NOTE: every variable gets a default before the case so no path leaves
    // it unassigned, which would otherwise infer a latch.
    always_comb begin
        state_next = state;
        shreg_next = shreg;
        bit_next   = bit_cnt;
        stop_next  = stop_cnt;
        par_next   = par_q;
        tx_next    = 1'b1;

        case (state)
            START: if (tick) begin
                state_next = DATA;
                bit_next   = '0;
            end
            DATA: if (tick) begin
                shreg_next = shreg >> 1;
                if (bit_cnt == LAST_BIT) begin
                    state_next = (PARITY != PAR_NONE) ? PAR : STOP;
                    stop_next  = 1'b0;
                end else begin
                    bit_next = bit_cnt + BW'(1);
                end
            end
            PAR: if (tick) begin
                state_next = STOP;
                stop_next  = 1'b0;
            end
            STOP: if (tick) begin
                if (stop_cnt == LAST_STOP) state_next = IDLE;
                else                       stop_next  = 1'b1;
            end
            default: state_next = IDLE;
        endcase

        // Acceptance from IDLE or the final stop cycle both go straight to START.
        if (accept) begin
            state_next = START;
            shreg_next = data;
            par_next   = (PARITY == PAR_ODD) ? ~^data : ^data;
        end

        // tx is registered from the next state so the line never glitches.
        case (state_next)
            START:   tx_next = 1'b0;
            DATA:    tx_next = shreg_next[0];
            PAR:     tx_next = par_q;
            default: tx_next = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            shreg    <= '0;
            bit_cnt  <= '0;
            stop_cnt <= 1'b0;
            par_q    <= 1'b0;
            tx_q     <= 1'b1;
        end else begin
            state    <= state_next;
            shreg    <= shreg_next;
            bit_cnt  <= bit_next;
            stop_cnt <= stop_next;
            par_q    <= par_next;
            tx_q     <= tx_next;
        end
    end

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Directed bench for uart_tx_cfg: four configurations share one clock and reset;
// expected line sequences are written out bit by bit, start bit first.
module tb_uart_tx_cfg;
    import uart_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] din;
    logic [3:0] send_v;
    wire  [3:0] ready_v, sent_v, busy_v, tx_v;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    uart_tx_cfg #(.CLKDIV(16), .DATA_BITS(8), .PARITY(PAR_NONE), .STOP_BITS(1)) u_8n1 (
        .clk(clk), .rst(rst), .data(din), .send(send_v[0]),
        .ready(ready_v[0]), .sent(sent_v[0]), .busy(busy_v[0]), .tx(tx_v[0]));

    uart_tx_cfg #(.CLKDIV(16), .DATA_BITS(8), .PARITY(PAR_ODD), .STOP_BITS(1)) u_8o1 (
        .clk(clk), .rst(rst), .data(din), .send(send_v[1]),
        .ready(ready_v[1]), .sent(sent_v[1]), .busy(busy_v[1]), .tx(tx_v[1]));

    uart_tx_cfg #(.CLKDIV(16), .DATA_BITS(8), .PARITY(PAR_EVEN), .STOP_BITS(1)) u_8e1 (
        .clk(clk), .rst(rst), .data(din), .send(send_v[2]),
        .ready(ready_v[2]), .sent(sent_v[2]), .busy(busy_v[2]), .tx(tx_v[2]));

    uart_tx_cfg #(.CLKDIV(1), .DATA_BITS(7), .PARITY(PAR_NONE), .STOP_BITS(2)) u_7n2 (
        .clk(clk), .rst(rst), .data(din[6:0]), .send(send_v[3]),
        .ready(ready_v[3]), .sent(sent_v[3]), .busy(busy_v[3]), .tx(tx_v[3]));

    // Sends one frame on instance idx and checks every cycle of it against exp,
    // a string of line levels in transmission order. With scramble set, data and
    // send are randomised on every cycle after acceptance.
    task automatic run_frame(input int idx, input logic [7:0] d, input string exp,
                             input int cdiv, input bit scramble, input string name);
        int          nbits;
        int          total;
        int          b;
        logic        e;
        logic [15:0] bad;
        logic [15:0] got;
        int          sent_at;
        int          sent_cnt;
        int          ready_bad;
        int          busy_bad;
        nbits     = exp.len();
        total     = nbits * cdiv;
        bad       = '0;
        got       = '0;
        sent_at   = -1;
        sent_cnt  = 0;
        ready_bad = 0;
        busy_bad  = 0;

        checks++;
        if (ready_v[idx] !== 1'b1) begin
            errors++;
            $display("FAIL %s ready_before_send got=%b exp=1", name, ready_v[idx]);
        end
        din         = d;
        send_v[idx] = 1'b1;
        @(negedge clk);
        send_v[idx] = 1'b0;

        for (int c = 1; c <= total; c++) begin
            b = (c - 1) / cdiv;
            e = (exp[b] == "1");
            if (tx_v[idx] !== e) begin
                bad[b] = 1'b1;
                got[b] = tx_v[idx];
            end
            if (sent_v[idx] === 1'b1) begin
                sent_cnt++;
                sent_at = c;
            end
            if (ready_v[idx] !== 1'(c == total)) ready_bad++;
            if (busy_v[idx] !== 1'b1) busy_bad++;
            if (scramble) begin
                din         = 8'($urandom);
                send_v[idx] = (c < total) ? 1'($urandom) : 1'b0;
            end
            @(negedge clk);
        end

        for (int i = 0; i < nbits; i++) begin
            checks++;
            if (bad[i]) begin
                errors++;
                $display("FAIL %s bit%0d tx got=%b exp=%s", name, i, got[i], exp.substr(i, i));
            end
        end
        checks++;
        if (sent_cnt != 1) begin
            errors++;
            $display("FAIL %s sent_count got=%0d exp=1", name, sent_cnt);
        end
        checks++;
        if (sent_at != total) begin
            errors++;
            $display("FAIL %s sent_cycle got=%0d exp=%0d", name, sent_at, total);
        end
        checks++;
        if (ready_bad != 0) begin
            errors++;
            $display("FAIL %s ready_profile bad_cycles got=%0d exp=0", name, ready_bad);
        end
        checks++;
        if (busy_bad != 0) begin
            errors++;
            $display("FAIL %s busy_profile bad_cycles got=%0d exp=0", name, busy_bad);
        end
        checks++;
        if (tx_v[idx] !== 1'b1 || busy_v[idx] !== 1'b0 || ready_v[idx] !== 1'b1) begin
            errors++;
            $display("FAIL %s idle_after tx/busy/ready got=%b%b%b exp=101",
                     name, tx_v[idx], busy_v[idx], ready_v[idx]);
        end
    endtask

    task automatic test_reset();
        rst    = 1'b1;
        din    = '0;
        send_v = '0;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if ({tx_v[i], ready_v[i], sent_v[i], busy_v[i]} !== 4'b1000) begin
                errors++;
                $display("FAIL reset_hold inst%0d tx/ready/sent/busy got=%b%b%b%b exp=1000",
                         i, tx_v[i], ready_v[i], sent_v[i], busy_v[i]);
            end
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (ready_v !== 4'b1111) begin
            errors++;
            $display("FAIL reset_release ready got=%b exp=1111", ready_v);
        end
    endtask

    task automatic test_frame_8n1();
        run_frame(0, 8'h5C, "0001110101", 16, 1'b0, "frame_8n1_5c");
    endtask

    task automatic test_parity();
        run_frame(2, 8'h5C, "00011101001", 16, 1'b0, "parity_even_5c");
        run_frame(1, 8'h5C, "00011101011", 16, 1'b0, "parity_odd_5c");
    endtask

    task automatic test_back_to_back();
        string exps [3];
        int    bad  [3];
        int    sent_cyc [3];
        int    nsent;
        int    ready_bad;
        int    f;
        int    b;
        logic  e;
        exps      = '{"0001110101", "0101110101", "0011110101"};
        bad       = '{0, 0, 0};
        sent_cyc  = '{-1, -1, -1};
        nsent     = 0;
        ready_bad = 0;

        din       = 8'h5C;
        send_v[0] = 1'b1;
        @(negedge clk);
        for (int c = 1; c <= 480; c++) begin
            f = (c - 1) / 160;
            b = ((c - 1) % 160) / 16;
            e = (exps[f][b] == "1");
            if (tx_v[0] !== e) bad[f]++;
            if (ready_v[0] !== 1'((c % 160) == 0)) ready_bad++;
            if (sent_v[0] === 1'b1) begin
                if (nsent < 3) sent_cyc[nsent] = c;
                nsent++;
                if (nsent < 3) din = din + 8'd1;
                else           send_v[0] = 1'b0;
            end
            @(negedge clk);
        end
        send_v[0] = 1'b0;

        for (int i = 0; i < 3; i++) begin
            checks++;
            if (bad[i] != 0) begin
                errors++;
                $display("FAIL b2b_frame%0d tx bad_cycles got=%0d exp=0", i, bad[i]);
            end
        end
        checks++;
        if (nsent != 3) begin
            errors++;
            $display("FAIL b2b_sent_count got=%0d exp=3", nsent);
        end
        checks++;
        if (sent_cyc[0] != 160) begin
            errors++;
            $display("FAIL b2b_first_sent got=%0d exp=160", sent_cyc[0]);
        end
        for (int i = 1; i < 3; i++) begin
            checks++;
            if (sent_cyc[i] - sent_cyc[i-1] != 160) begin
                errors++;
                $display("FAIL b2b_sent_spacing%0d got=%0d exp=160", i, sent_cyc[i] - sent_cyc[i-1]);
            end
        end
        checks++;
        if (ready_bad != 0) begin
            errors++;
            $display("FAIL b2b_ready_profile bad_cycles got=%0d exp=0", ready_bad);
        end
        checks++;
        if (tx_v[0] !== 1'b1 || busy_v[0] !== 1'b0) begin
            errors++;
            $display("FAIL b2b_idle_after tx/busy got=%b%b exp=10", tx_v[0], busy_v[0]);
        end
    endtask

    task automatic test_reset_mid_frame();
        int sent_seen;
        int tx_low;
        sent_seen = 0;
        tx_low    = 0;

        din       = 8'h5C;
        send_v[0] = 1'b1;
        @(negedge clk);
        send_v[0] = 1'b0;
        repeat (49) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({tx_v[0], busy_v[0], ready_v[0], sent_v[0]} !== 4'b1000) begin
            errors++;
            $display("FAIL abort_in_reset tx/busy/ready/sent got=%b%b%b%b exp=1000",
                     tx_v[0], busy_v[0], ready_v[0], sent_v[0]);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (ready_v[0] !== 1'b1 || busy_v[0] !== 1'b0) begin
            errors++;
            $display("FAIL abort_release ready/busy got=%b%b exp=10", ready_v[0], busy_v[0]);
        end
        // Long enough that a surviving frame would have finished.
        for (int c = 0; c < 130; c++) begin
            if (sent_v[0] === 1'b1) sent_seen++;
            if (tx_v[0] !== 1'b1) tx_low++;
            @(negedge clk);
        end
        checks++;
        if (sent_seen != 0) begin
            errors++;
            $display("FAIL abort_no_sent got=%0d exp=0", sent_seen);
        end
        checks++;
        if (tx_low != 0) begin
            errors++;
            $display("FAIL abort_line_idle low_cycles got=%0d exp=0", tx_low);
        end
        run_frame(0, 8'hA5, "0101001011", 16, 1'b0, "after_abort_a5");
    endtask

    task automatic test_corner();
        run_frame(3, 8'h7F, "0111111111", 1, 1'b0, "corner_7n2_div1");
    endtask

    task automatic test_data_stability();
        run_frame(0, 8'h3C, "0001111001", 16, 1'b1, "data_stability_3c");
    endtask

    initial begin
        test_reset();
        test_frame_8n1();
        test_parity();
        test_back_to_back();
        test_reset_mid_frame();
        test_corner();
        test_data_stability();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
